muli_elastic_pipe: RTL and testbench

- Parametrised elastic successor to the fixed-latency arithmetic wrappers: an integer multiplier with a configurable LATENCY-stage datapath.
- The datapath never stalls. Every accepted operand pair advances one stage per cycle.
- Backpressure is absorbed by an output FIFO guarded by a credit counter, so throughput is 1 result/cycle whenever result_ready is high.
- Sits between Dynamatic handshake channels wherever a muli with latency > 0 is placed.

---
 rtl/muli_elastic_pipe.sv | 140 ++++++++++++++
 tb/tb_muli_elastic_pipe.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muli_elastic_pipe.sv
// Elastic integer multiplier: fixed-latency, never-stalling datapath feeding an
// output FIFO. A credit counter admits new operand pairs only when a FIFO slot
// is guaranteed for them, so the datapath never has to stall.
module muli_elastic_pipe #(
  parameter int unsigned DATA_TYPE  = 32,
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_TYPE-1:0] lhs,
  input  logic                 lhs_valid,
  input  logic [DATA_TYPE-1:0] rhs,
  input  logic                 rhs_valid,
  input  logic                 result_ready,
  output logic [DATA_TYPE-1:0] result,
  output logic                 result_valid,
  output logic                 lhs_ready,
  output logic                 rhs_ready
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [CntW-1:0]      count_q, count_d;
  logic [CntW-1:0]      occ_q, occ_d;
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [DATA_TYPE-1:0] mem_q [FIFO_DEPTH];

  logic                 pop;
  logic                 credit_ok;
  logic                 accept;
  logic                 push;
  logic [DATA_TYPE-1:0] push_data;

  // Handshake: a same-cycle pop frees a credit; readies are forced low in reset.
  assign result_valid = (occ_q != '0);
  assign result       = mem_q[rd_ptr_q];
  assign pop          = result_valid & result_ready;
  assign credit_ok    = (count_q < CntW'(FIFO_DEPTH)) | pop;
  assign lhs_ready    = rst & rhs_valid & credit_ok;
  assign rhs_ready    = rst & lhs_valid & credit_ok;
  assign accept       = rst & lhs_valid & rhs_valid & credit_ok;

  // Datapath: LATENCY-1 register stages, the FIFO write is the final stage.
  if (LATENCY == 1) begin : g_lat1
    assign push      = accept;
    assign push_data = lhs * rhs;
  end else begin : g_pipe
    logic                 s0_valid_q;
    logic [DATA_TYPE-1:0] s0_lhs_q, s0_rhs_q;
    logic [DATA_TYPE-1:0] prod;

    // Stage 0 valid: records whether an accept happened this edge.
    always_ff @(posedge clk) begin
      if (!rst) s0_valid_q <= 1'b0;
      else      s0_valid_q <= accept;
    end

    // Stage 0 operands: only loaded on accept, otherwise don't-care.
    always_ff @(posedge clk) begin
      if (accept) begin
        s0_lhs_q <= lhs;
        s0_rhs_q <= rhs;
      end
    end

    assign prod = s0_lhs_q * s0_rhs_q;

    if (LATENCY == 2) begin : g_direct
      assign push      = s0_valid_q;
      assign push_data = prod;
    end else begin : g_tail
      localparam int unsigned TailN = LATENCY - 2;
      logic [TailN-1:0]     tail_valid_q;
      logic [DATA_TYPE-1:0] tail_data_q [TailN];

      // Tail valids shift unconditionally; bubbles travel like data.
      always_ff @(posedge clk) begin
        if (!rst) begin
          tail_valid_q <= '0;
        end else begin
          tail_valid_q[0] <= s0_valid_q;
          for (int i = 1; i < int'(TailN); i++) tail_valid_q[i] <= tail_valid_q[i-1];
        end
      end

      // Tail data shifts alongside its valid bit.
      always_ff @(posedge clk) begin
        tail_data_q[0] <= prod;
        for (int i = 1; i < int'(TailN); i++) tail_data_q[i] <= tail_data_q[i-1];
      end

      assign push      = tail_valid_q[TailN-1];
      assign push_data = tail_data_q[TailN-1];
    end
  end

  // Next-state for credits, FIFO occupancy and wrapping pointers.
  always_comb begin
    count_d  = count_q + CntW'(accept) - CntW'(pop);
    occ_d    = occ_q + CntW'(push) - CntW'(pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q  <= '0;
      occ_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // FIFO storage write.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

`ifndef SYNTHESIS
  // Credit accounting must make overflow impossible.
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!(push && occ_q == CntW'(FIFO_DEPTH))) else $error("push into full fifo");
      assert (count_q <= CntW'(FIFO_DEPTH)) else $error("credit count overflow");
    end
  end
`endif

endmodule

// File: tb/tb_muli_elastic_pipe.sv
// Directed bench for muli_elastic_pipe (DATA_TYPE=32, LATENCY=4, FIFO_DEPTH=4).
module tb_muli_elastic_pipe;

  localparam int unsigned W     = 32;
  localparam int unsigned LAT   = 4;
  localparam int unsigned DEPTH = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] lhs, rhs, result;
  logic         lhs_valid, rhs_valid, result_ready;
  logic         result_valid, lhs_ready, rhs_ready;

  int errors = 0;
  int checks = 0;

  muli_elastic_pipe #(
    .DATA_TYPE (W),
    .LATENCY   (LAT),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .lhs         (lhs),
    .lhs_valid   (lhs_valid),
    .rhs         (rhs),
    .rhs_valid   (rhs_valid),
    .result_ready(result_ready),
    .result      (result),
    .result_valid(result_valid),
    .lhs_ready   (lhs_ready),
    .rhs_ready   (rhs_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hold reset with valids high: no readies, no result.
  task automatic test_reset();
    rst = 1'b0; lhs = 1; rhs = 1; lhs_valid = 1'b1; rhs_valid = 1'b1; result_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (result_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected 0", result_valid);
    end
    checks++;
    if ({lhs_ready, rhs_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_ready: got %b expected 00", {lhs_ready, rhs_ready});
    end
    rst = 1'b1; lhs_valid = 1'b0; rhs_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (result_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release_valid: got %b expected 0", result_valid);
    end
  endtask

  // 7*6 appears exactly LATENCY cycles after the accept, for one cycle.
  task automatic test_single_op();
    result_ready = 1'b1; lhs = 7; rhs = 6; lhs_valid = 1'b1; rhs_valid = 1'b1;
    #1;
    checks++;
    if ({lhs_ready, rhs_ready} !== 2'b11) begin
      errors++; $display("FAIL single_ready: got %b expected 11", {lhs_ready, rhs_ready});
    end
    for (int c = 1; c < int'(LAT); c++) begin
      @(negedge clk);
      lhs_valid = 1'b0; rhs_valid = 1'b0;
      checks++;
      if (result_valid !== 1'b0) begin
        errors++; $display("FAIL single_early_c%0d: got %b expected 0", c, result_valid);
      end
    end
    @(negedge clk);
    checks++;
    if (result_valid !== 1'b1 || result !== 32'd42) begin
      errors++;
      $display("FAIL single_result: got v=%b r=%0d expected v=1 r=42", result_valid, result);
    end
    @(negedge clk);
    checks++;
    if (result_valid !== 1'b0) begin
      errors++; $display("FAIL single_one_cycle: got %b expected 0", result_valid);
    end
  endtask

  // Truncation of the full product to the low 32 bits.
  task automatic test_wrap();
    int n = 0;
    result_ready = 1'b1;
    lhs = 32'hFFFF_FFFF; rhs = 32'd2; lhs_valid = 1'b1; rhs_valid = 1'b1;
    @(negedge clk);
    lhs = 32'h8000_0000; rhs = 32'h8000_0000;
    @(negedge clk);
    lhs_valid = 1'b0; rhs_valid = 1'b0;
    while (!result_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (result_valid !== 1'b1 || result !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL wrap_ff_x2: got v=%b r=%h expected v=1 r=fffffffe", result_valid, result);
    end
    @(negedge clk);
    checks++;
    if (result_valid !== 1'b1 || result !== 32'h0) begin
      errors++;
      $display("FAIL wrap_msb_sq: got v=%b r=%h expected v=1 r=00000000", result_valid, result);
    end
    @(negedge clk);
    checks++;
    if (result_valid !== 1'b0) begin
      errors++; $display("FAIL wrap_empty: got %b expected 0", result_valid);
    end
  endtask

  // 20 back-to-back pairs: readies stay high, results contiguous and in order.
  task automatic test_back_to_back();
    int ridx = 0;
    int bubbles = 0;
    int rdy_bad = 0;
    bit started = 1'b0;
    logic [W-1:0] exp;
    result_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (result_valid) begin
        exp = 32'(ridx * (ridx + 1));
        checks++;
        if (result !== exp) begin
          errors++; $display("FAIL stream_r%0d: got %0d expected %0d", ridx, result, exp);
        end
        ridx++;
        started = 1'b1;
      end else if (started && ridx < 20) begin
        bubbles++;
      end
      if (c < 20) begin
        lhs = 32'(c); rhs = 32'(c + 1); lhs_valid = 1'b1; rhs_valid = 1'b1;
        #1;
        if (!(lhs_ready && rhs_ready)) rdy_bad++;
      end else begin
        lhs_valid = 1'b0; rhs_valid = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if (ridx != 20) begin
      errors++; $display("FAIL stream_count: got %0d expected 20", ridx);
    end
    checks++;
    if (bubbles != 0) begin
      errors++; $display("FAIL stream_bubbles: got %0d expected 0", bubbles);
    end
    checks++;
    if (rdy_bad != 0) begin
      errors++; $display("FAIL stream_ready_drops: got %0d expected 0", rdy_bad);
    end
  endtask

  // Consumer stalled: exactly DEPTH accepts, then one pop admits one pair.
  task automatic test_backpressure();
    int acc = 0;
    int got = 1;
    logic [W-1:0] exp_q [5] = '{32'd6, 32'd9, 32'd12, 32'd15, 32'd18};
    result_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      lhs = 32'(acc + 2); rhs = 32'd3; lhs_valid = 1'b1; rhs_valid = 1'b1;
      #1;
      if (lhs_ready && rhs_ready) acc++;
      @(negedge clk);
    end
    checks++;
    if (acc != 4) begin
      errors++; $display("FAIL bp_accepts: got %0d expected 4", acc);
    end
    lhs = 32'(acc + 2);
    #1;
    checks++;
    if ({lhs_ready, rhs_ready} !== 2'b00) begin
      errors++; $display("FAIL bp_ready_full: got %b expected 00", {lhs_ready, rhs_ready});
    end
    checks++;
    if (result_valid !== 1'b1 || result !== 32'd6) begin
      errors++; $display("FAIL bp_head: got v=%b r=%0d expected v=1 r=6", result_valid, result);
    end
    result_ready = 1'b1;
    #1;
    checks++;
    if ({lhs_ready, rhs_ready} !== 2'b11) begin
      errors++; $display("FAIL bp_ready_pop: got %b expected 11", {lhs_ready, rhs_ready});
    end
    @(negedge clk);
    result_ready = 1'b0; lhs_valid = 1'b0; rhs_valid = 1'b0;
    checks++;
    if (result_valid !== 1'b1 || result !== 32'd9) begin
      errors++; $display("FAIL bp_after_pop: got v=%b r=%0d expected v=1 r=9", result_valid, result);
    end
    result_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (result_valid) begin
        checks++;
        if (got > 4 || result !== exp_q[got]) begin
          errors++;
          $display("FAIL bp_drain_%0d: got %0d expected %0d", got, result, exp_q[got > 4 ? 4 : got]);
        end
        got++;
      end
      @(negedge clk);
    end
    checks++;
    if (got != 5) begin
      errors++; $display("FAIL bp_total: got %0d expected 5", got);
    end
  endtask

  // Join: lhs alone is never consumed; rhs arriving triggers a single accept.
  task automatic test_join();
    int seen = 0;
    result_ready = 1'b1; lhs = 9; rhs = 4; lhs_valid = 1'b1; rhs_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if ({lhs_ready, rhs_ready} !== 2'b01) begin
        errors++; $display("FAIL join_wait_c%0d: got %b expected 01", c, {lhs_ready, rhs_ready});
      end
      @(negedge clk);
    end
    rhs_valid = 1'b1;
    #1;
    checks++;
    if ({lhs_ready, rhs_ready} !== 2'b11) begin
      errors++; $display("FAIL join_both: got %b expected 11", {lhs_ready, rhs_ready});
    end
    @(negedge clk);
    lhs_valid = 1'b0; rhs_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (result_valid) begin
        seen++;
        checks++;
        if (result !== 32'd36) begin
          errors++; $display("FAIL join_result: got %0d expected 36", result);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (seen != 1) begin
      errors++; $display("FAIL join_count: got %0d expected 1", seen);
    end
  endtask

  // Reset with three pairs in flight discards them all.
  task automatic test_reset_midflight();
    int bad = 0;
    result_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      lhs = 32'(k + 1); rhs = 32'd2; lhs_valid = 1'b1; rhs_valid = 1'b1;
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({lhs_ready, rhs_ready} !== 2'b00) begin
      errors++; $display("FAIL mid_reset_ready: got %b expected 00", {lhs_ready, rhs_ready});
    end
    @(negedge clk);
    rst = 1'b1; lhs_valid = 1'b0; rhs_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (result_valid) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL mid_flushed: got %0d valid cycles expected 0", bad);
    end
    lhs = 3; rhs = 5; lhs_valid = 1'b1; rhs_valid = 1'b1;
    for (int c = 1; c < int'(LAT); c++) begin
      @(negedge clk);
      lhs_valid = 1'b0; rhs_valid = 1'b0;
      checks++;
      if (result_valid !== 1'b0) begin
        errors++; $display("FAIL mid_early_c%0d: got %b expected 0", c, result_valid);
      end
    end
    @(negedge clk);
    checks++;
    if (result_valid !== 1'b1 || result !== 32'd15) begin
      errors++; $display("FAIL mid_result: got v=%b r=%0d expected v=1 r=15", result_valid, result);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_op();
    test_wrap();
    test_back_to_back();
    test_backpressure();
    test_join();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
